// File: rtl/fdc_host_bridge.sv
// CPU-side front end for 1..4 WD1793 drives: control register, CE divider, strobe-to-pulse bridge.
// Optional auto motor-off is built when MOTOR_TIMEOUT_EN is defined.
module fdc_host_bridge #(
  parameter int          NUM_DRIVES  = 4,
  parameter int          CE_DIV      = 6,
  parameter logic [23:0] MOTOR_TICKS = 24'd10_000_000
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic [3:0]              ADDRESS,
  input  logic [7:0]              DATA_IN,
  input  logic                    CTRL_WR,
  input  logic                    CTRL_RD,
  input  logic                    FDC_RD_STB,
  input  logic                    FDC_WR_STB,
  input  logic [8*NUM_DRIVES-1:0] DRV_DOUT,
  input  logic [NUM_DRIVES-1:0]   DRV_DRQ,
  input  logic [NUM_DRIVES-1:0]   DRV_INTRQ,
  output logic                    CE,
  output logic [NUM_DRIVES-1:0]   DRV_RD,
  output logic [NUM_DRIVES-1:0]   DRV_WR,
  output logic [1:0]              DRV_ADDR,
  output logic [7:0]              DRV_DIN,
  output logic                    DRV_SIDE,
  output logic [1:0]              DRV_INDEX,
  output logic [7:0]              DATA_OUT,
  output logic                    HALT,
  output logic                    NMI,
  output logic                    MOTOR_ON
);
  localparam int CW = $clog2(CE_DIV);

  typedef enum logic [1:0] {IDLE, WAITCE, PULSE} state_t;

  state_t          state, nxt;
  logic [CW-1:0]   ce_cnt;
  logic [2:0]      rd_pipe, wr_pipe;
  logic            rd_trig, wr_trig, trig, s1_rise;
  logic [2:0]      ds;
  logic            motor, precomp, density, b6, halt_en;
  logic [1:0]      tgt;
  logic            kind_wr;
  logic            dec_ok, dec_side;
  logic [1:0]      dec_idx;
  logic [7:0]      sel_dout;
  logic            sel_drq, sel_intrq;
  logic            motor_expire;
  logic            unused_bits;

  assign CE = (ce_cnt == CW'(CE_DIV - 1));

  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N)  ce_cnt <= '0;
    else if (CE)   ce_cnt <= '0;
    else           ce_cnt <= ce_cnt + 1'b1;

  // pipe[0]/pipe[1] are synchroniser stages 1/2; pipe[2] only serves stage-2 edge detection
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      rd_pipe <= '0;
      wr_pipe <= '0;
    end else begin
      rd_pipe <= {rd_pipe[1:0], FDC_RD_STB};
      wr_pipe <= {wr_pipe[1:0], FDC_WR_STB};
    end

  assign s1_rise = (rd_pipe[0] & ~rd_pipe[1]) | (wr_pipe[0] & ~wr_pipe[1]);
  assign rd_trig = rd_pipe[1] & ~rd_pipe[2];
  assign wr_trig = wr_pipe[1] & ~wr_pipe[2];
  assign trig    = rd_trig | wr_trig;

  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      DRV_ADDR <= '0;
      DRV_DIN  <= '0;
    end else if (s1_rise) begin
      DRV_ADDR <= ADDRESS[1:0];
      DRV_DIN  <= DATA_IN;
    end

  always_comb begin
    dec_ok   = 1'b1;
    dec_side = 1'b0;
    dec_idx  = 2'd0;
    case ({DATA_IN[6], DATA_IN[2:0]})
      4'b1000: dec_idx = 2'd3;
      4'b0100: dec_idx = 2'd2;
      4'b0010: dec_idx = 2'd1;
      4'b0001: dec_idx = 2'd0;
      4'b1100: begin dec_idx = 2'd2; dec_side = 1'b1; end
      4'b1010: begin dec_idx = 2'd1; dec_side = 1'b1; end
      4'b1001: begin dec_idx = 2'd0; dec_side = 1'b1; end
      default: dec_ok = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      ds <= '0; motor <= 1'b0; precomp <= 1'b0; density <= 1'b0; b6 <= 1'b0;
      halt_en <= 1'b0; DRV_INDEX <= '0; DRV_SIDE <= 1'b0;
    end else begin
      if (CTRL_WR) begin
        ds      <= DATA_IN[2:0];
        motor   <= DATA_IN[3];
        precomp <= DATA_IN[4];
        density <= DATA_IN[5];
        b6      <= DATA_IN[6];
        if (dec_ok) begin
          DRV_INDEX <= dec_idx;
          DRV_SIDE  <= dec_side;
        end
      end else if (motor_expire) begin
        motor <= 1'b0;
      end
      // a pending interrupt beats a simultaneous attempt to re-arm halt
      if (sel_intrq)     halt_en <= 1'b0;
      else if (CTRL_WR)  halt_en <= DATA_IN[7];
    end

  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) state <= IDLE;
    else          state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (trig) nxt = WAITCE;
      WAITCE:  if (CE)   nxt = PULSE;
      PULSE:   if (CE)   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      tgt     <= '0;
      kind_wr <= 1'b0;
    end else if (state == IDLE && trig) begin
      tgt     <= DRV_INDEX;
      kind_wr <= wr_trig;
    end

  // drive indices beyond NUM_DRIVES fall through to the defaults: DRQ=1, INTRQ=0, data 00, no pulse
  always_comb begin
    DRV_RD    = '0;
    DRV_WR    = '0;
    sel_dout  = 8'h00;
    sel_drq   = 1'b1;
    sel_intrq = 1'b0;
    for (int i = 0; i < NUM_DRIVES; i++) begin
      if (state == PULSE && tgt == 2'(i)) begin
        DRV_WR[i] = kind_wr;
        DRV_RD[i] = ~kind_wr;
      end
      if (DRV_INDEX == 2'(i)) begin
        sel_dout  = DRV_DOUT[8*i +: 8];
        sel_drq   = DRV_DRQ[i];
        sel_intrq = DRV_INTRQ[i];
        if (rd_pipe[1] && !kind_wr && state != IDLE) DRV_RD[i] = 1'b1;
      end
    end
  end

  assign DATA_OUT = CTRL_RD    ? {halt_en, b6, density, precomp, motor, ds} :
                    rd_pipe[1] ? sel_dout : 8'h00;
  assign NMI      = density & sel_intrq;
  assign HALT     = halt_en & ~sel_drq;
  assign MOTOR_ON = motor;

`ifdef MOTOR_TIMEOUT_EN
  logic [23:0] idle_cnt;

  assign motor_expire = motor && (idle_cnt == MOTOR_TICKS);
  assign unused_bits  = ^ADDRESS[3:2];

  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N)                                   idle_cnt <= '0;
    else if (CTRL_WR || trig || state != IDLE)      idle_cnt <= '0;
    else if (motor && idle_cnt != MOTOR_TICKS)      idle_cnt <= idle_cnt + 24'd1;
`else
  assign motor_expire = 1'b0;
  assign unused_bits  = ^{ADDRESS[3:2], MOTOR_TICKS};
`endif

endmodule

// File: tb/tb_fdc_host_bridge.sv
// Directed bench for fdc_host_bridge; a monitor pops expected accesses from a scoreboard as pulses finish.
module tb_fdc_host_bridge;
  localparam int ND = 4;
  localparam int CD = 6;
`ifdef MOTOR_TIMEOUT_EN
  localparam logic [23:0] MT = 24'd100;
`else
  localparam logic [23:0] MT = 24'd10_000_000;
`endif

  logic          CLK = 0, RESET_N = 0;
  logic [3:0]    ADDRESS = 0;
  logic [7:0]    DATA_IN = 0;
  logic          CTRL_WR = 0, CTRL_RD = 0, FDC_RD_STB = 0, FDC_WR_STB = 0;
  logic [8*ND-1:0] DRV_DOUT = 0;
  logic [ND-1:0] DRV_DRQ = 0, DRV_INTRQ = 0;
  logic          CE;
  logic [ND-1:0] DRV_RD, DRV_WR;
  logic [1:0]    DRV_ADDR, DRV_INDEX;
  logic [7:0]    DRV_DIN, DATA_OUT;
  logic          DRV_SIDE, HALT, NMI, MOTOR_ON;

  fdc_host_bridge #(.NUM_DRIVES(ND), .CE_DIV(CD), .MOTOR_TICKS(MT)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .ADDRESS(ADDRESS), .DATA_IN(DATA_IN),
    .CTRL_WR(CTRL_WR), .CTRL_RD(CTRL_RD), .FDC_RD_STB(FDC_RD_STB), .FDC_WR_STB(FDC_WR_STB),
    .DRV_DOUT(DRV_DOUT), .DRV_DRQ(DRV_DRQ), .DRV_INTRQ(DRV_INTRQ), .CE(CE),
    .DRV_RD(DRV_RD), .DRV_WR(DRV_WR), .DRV_ADDR(DRV_ADDR), .DRV_DIN(DRV_DIN),
    .DRV_SIDE(DRV_SIDE), .DRV_INDEX(DRV_INDEX), .DATA_OUT(DATA_OUT),
    .HALT(HALT), .NMI(NMI), .MOTOR_ON(MOTOR_ON));

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0] wr;
    logic [3:0] rd;
    logic [1:0] addr;
    logic [7:0] din;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // pulse monitor: accumulates one access and scores it when the pulse ends
  logic [3:0] cur_wr, cur_rd, prev_pv;
  logic [1:0] cur_addr;
  logic [7:0] cur_din;
  int         width, ces;
  logic       active = 0;
  initial prev_pv = 0;

  always @(negedge CLK) begin
    logic [3:0] pv;
    exp_t e;
    if (!RESET_N) begin
      active = 0; prev_pv = 0;
    end else begin
      pv = DRV_WR | DRV_RD;
      if (pv != 0 && prev_pv == 0) begin
        active = 1; width = 0; ces = 0; cur_wr = 0; cur_rd = 0;
        cur_addr = DRV_ADDR; cur_din = DRV_DIN;
      end
      if (pv != 0) begin
        width++;
        if (CE) ces++;
        cur_wr |= DRV_WR;
        cur_rd |= DRV_RD;
      end
      if (pv == 0 && prev_pv != 0) begin
        active = 0;
        if (sb.size() == 0) chk("unexpected_pulse", {24'd0, cur_wr, cur_rd}, 0);
        else begin
          e = sb.pop_front();
          chk("pulse_wr", cur_wr, e.wr);
          chk("pulse_rd", cur_rd, e.rd);
          chk("pulse_addr", cur_addr, e.addr);
          chk("pulse_din", cur_din, e.din);
          if (e.wr != 0) begin
            chk("wr_ce_count", ces, 1);
            chk("wr_width_ok", (width >= 1 && width <= CD + 1), 1);
          end else chk("rd_covers_ce", ces >= 1, 1);
        end
      end
      prev_pv = pv;
    end
  end

  task automatic ctrl_write(input logic [7:0] v);
    @(posedge CLK); #1;
    DATA_IN = v; CTRL_WR = 1;
    @(posedge CLK); #1;
    CTRL_WR = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    idle(2);
    while ((sb.size() != 0 || active) && n < 60) begin @(negedge CLK); n++; end
    chk(tag, sb.size(), 0);
  endtask

  task automatic push(input logic [3:0] wr, input logic [3:0] rd, input logic [1:0] a, input logic [7:0] d);
    exp_t e;
    e.wr = wr; e.rd = rd; e.addr = a; e.din = d;
    sb.push_back(e);
  endtask

  initial begin
    int n;
    // reset state
    idle(3);
    chk("rst_outs", {CE, DRV_RD, DRV_WR, DRV_ADDR, DRV_DIN, DRV_SIDE, DRV_INDEX, HALT, NMI, MOTOR_ON}, 0);
    chk("rst_data_out", DATA_OUT, 0);
    @(posedge CLK); #1 RESET_N = 1;
    idle(1);
    chk("ce_after_rst", CE, 0);
    n = 0;
    while (!CE && n < 20) begin @(negedge CLK); n++; end
    @(negedge CLK);
    n = 1;
    while (!CE && n < 20) begin @(negedge CLK); n++; end
    chk("ce_period", n, CD);

    // drive decode
    ctrl_write(8'h42);
    idle(1);
    chk("idx_42", DRV_INDEX, 1);
    chk("side_42", DRV_SIDE, 1);
    ctrl_write(8'h45);
    idle(1);
    chk("idx_held_45", DRV_INDEX, 1);
    CTRL_RD = 1;
    idle(1);
    chk("ctrl_rd_45", DATA_OUT, 8'h45);
    CTRL_RD = 0;
    ctrl_write(8'h48);
    idle(1);
    chk("idx_single_b6", DRV_INDEX, 3);
    chk("side_single_b6", DRV_SIDE, 0);
    chk("motor_bit", MOTOR_ON, 1);

    // write to drive 2
    ctrl_write(8'h04);
    idle(1);
    chk("idx_2", DRV_INDEX, 2);
    @(posedge CLK); #1;
    ADDRESS = 4'd3; DATA_IN = 8'h5A;
    push(4'b0100, 4'b0000, 2'd3, 8'h5A);
    FDC_WR_STB = 1;
    drain("wr_drive2_done");
    chk("drv_addr", DRV_ADDR, 3);
    chk("drv_din", DRV_DIN, 8'h5A);
    FDC_WR_STB = 0;
    idle(4);

    // simultaneous read and write: write wins
    ctrl_write(8'h02);
    @(posedge CLK); #1;
    ADDRESS = 4'd1; DATA_IN = 8'h77;
    push(4'b0010, 4'b0000, 2'd1, 8'h77);
    FDC_WR_STB = 1; FDC_RD_STB = 1;
    drain("wr_wins_done");
    idle(8);
    FDC_WR_STB = 0; FDC_RD_STB = 0;
    idle(8);
    chk("no_late_read", sb.size(), 0);

    // read from drive 0
    ctrl_write(8'h01);
    DRV_DOUT = {8'h44, 8'h33, 8'h22, 8'h11};
    @(posedge CLK); #1;
    ADDRESS = 4'd2; DATA_IN = 8'h00;
    push(4'b0000, 4'b0001, 2'd2, 8'h00);
    FDC_RD_STB = 1;
    idle(3);
    chk("rd_data_out", DATA_OUT, 8'h11);
    drain("rd_drive0_done");
    FDC_RD_STB = 0;
    idle(3);
    chk("rd_data_idle", DATA_OUT, 0);

    // control write mid-access keeps the original target
    ctrl_write(8'h04);
    @(posedge CLK); #1;
    ADDRESS = 4'd0; DATA_IN = 8'h99;
    push(4'b0100, 4'b0000, 2'd0, 8'h99);
    FDC_WR_STB = 1;
    idle(4);
    ctrl_write(8'h01);
    drain("retarget_done");
    chk("idx_after_retarget", DRV_INDEX, 0);
    FDC_WR_STB = 0;
    idle(4);

    // halt / nmi on drive 0
    ctrl_write(8'hA0);
    idle(1);
    chk("halt_set", HALT, 1);
    chk("nmi_idle", NMI, 0);
    @(posedge CLK); #1 DRV_INTRQ[0] = 1;
    @(negedge CLK);
    chk("nmi_set", NMI, 1);
    @(negedge CLK);
    chk("halt_cleared", HALT, 0);
    ctrl_write(8'hA0);
    CTRL_RD = 1;
    idle(1);
    chk("halt_override", DATA_OUT, 8'h20);
    CTRL_RD = 0;
    @(posedge CLK); #1 DRV_INTRQ[0] = 0; DRV_DRQ[0] = 1;
    ctrl_write(8'hA0);
    idle(1);
    chk("halt_drq_blocks", HALT, 0);
    CTRL_RD = 1;
    idle(1);
    chk("halt_en_rearmed", DATA_OUT, 8'hA0);
    CTRL_RD = 0;
    DRV_DRQ[0] = 0;
    idle(1);
    chk("halt_drq_low", HALT, 1);

    // async reset mid-pulse drops the pulse at once
    @(posedge CLK); #1 FDC_WR_STB = 1;
    n = 0;
    while (DRV_WR == 0 && n < 30) begin @(negedge CLK); n++; end
    chk("pulse_seen_before_rst", DRV_WR, 4'b0001);
    #1 RESET_N = 0;
    #1 chk("pulse_dropped_rst", DRV_WR, 0);
    FDC_WR_STB = 0;
    idle(3);
    @(posedge CLK); #1 RESET_N = 1;
    idle(2);
    chk("idx_after_rst", DRV_INDEX, 0);

`ifdef MOTOR_TIMEOUT_EN
    ctrl_write(8'h08);
    idle(50);
    chk("motor_on_50", MOTOR_ON, 1);
    @(posedge CLK); #1;
    ADDRESS = 4'd1; DATA_IN = 8'h12;
    push(4'b0001, 4'b0000, 2'd1, 8'h12);
    FDC_WR_STB = 1;
    drain("motor_access_done");
    FDC_WR_STB = 0;
    n = 0;
    while (MOTOR_ON && n < 300) begin @(negedge CLK); n++; end
    chk("motor_restart_window", (n >= 95 && n <= 110), 1);
    chk("motor_off", MOTOR_ON, 0);
`endif

    idle(5);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
